fp_addsub_sequencer: RTL and testbench
======================================

FP_ADDSUB_SEQUENCER -- requirements
Module: fp_addsub_sequencer

Interface
REQ-001 SHALL have parameter EXPO_WIDTH, default 8: exponent field width.
REQ-002 SHALL have parameter MENT_WIDTH, default 23: stored mantissa width, without the hidden bit.
REQ-003 SHALL have parameter DATA_WIDTH, default 32: operand width, equal to 1+EXPO_WIDTH+MENT_WIDTH.
REQ-004 SHALL have clk_in, input, 1: single clock, rising edge.
REQ-005 SHALL have rst_in, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have in_valid_in, input, 1: operands and op valid.
REQ-007 SHALL have in_ready_out, output, 1: sequencer accepts an operation.
REQ-008 SHALL have floating1_in and floating2_in, input, DATA_WIDTH each: operands {sign, exponent, mantissa}.
REQ-009 SHALL have op_in, input, 1: 0 = add, 1 = subtract (floating1 - floating2).
REQ-010 SHALL have out_valid_out, output, 1: result valid.
REQ-011 SHALL have out_ready_in, input, 1: consumer takes the result.
REQ-012 SHALL have result_out, output, DATA_WIDTH: result.
REQ-013 SHALL have zero_out, overflow_out and underflow_out, output, 1 each: result status flags.

Function
REQ-014 SHALL implement a single FSM with states IDLE, ALIGN, ADD, NORM, DONE. Transitions:
- IDLE->ALIGN on in_valid_in & in_ready_out.
- ALIGN->ADD, ADD->NORM and NORM->DONE unconditionally.
- DONE->IDLE on out_ready_in.
REQ-015 SHALL assert in_ready_out only in IDLE; operands and op SHALL be registered on the accepting edge.
REQ-016 SHALL assert out_valid_out only in DONE, first visible 4 clock edges after the accepting edge, and hold result_out and the flags stable until out_ready_in.
REQ-017 ALIGN SHALL select the larger-magnitude operand by exponent, then mantissa. The smaller operand's {1,mantissa} SHALL be right-shifted by the exponent difference; a difference >= MENT_WIDTH+2 SHALL yield zero.
REQ-018 ADD SHALL use effective subtraction = op_in ^ sign1 ^ sign2 on a MENT_WIDTH+2-bit datapath that includes the carry bit.
REQ-019 NORM SHALL normalise the sum:
- carry set: shift right 1, exponent+1.
- otherwise: shift left by MENT_WIDTH minus the leading-one position, exponent minus the same amount.
REQ-020 Result sign SHALL be the larger operand's sign, with floating2's sign inverted when op_in=1. An exact zero result SHALL be +0 with zero_out=1.
REQ-021 Rounding SHALL be truncation; bits shifted out SHALL be discarded.
REQ-022 An input exponent of 0 SHALL be treated as zero (flush denormals).
REQ-023 An input exponent of all-ones SHALL produce exponent all-ones, mantissa 0, sign of that operand (floating1 if both), overflow_out=0.
REQ-024 If the post-normalisation exponent >= all-ones, the result SHALL be infinity with overflow_out=1. If it is <= 0, the result SHALL be +0 with underflow_out=1 and zero_out=1.
REQ-025 in_valid_in outside IDLE SHALL be ignored and SHALL NOT corrupt the operation in flight.

Reset
REQ-026 rst_in SHALL asynchronously force state IDLE, in_ready_out=0 while asserted, and out_valid_out, result_out and all flags to 0.
REQ-027 in_ready_out SHALL rise on the first edge after rst_in deasserts.
REQ-028 Reset mid-operation SHALL discard that operation; no result SHALL ever be presented for it.

Structure
REQ-029 Package fp_pkg SHALL hold the FSM state encoding, the default width constants and the all-ones exponent constant.
REQ-030 The leading-one search SHALL be sub-module leading_one_detector, parametrised by width, outputting position and a valid bit (0 for all-zero input).
REQ-031 The exponent datapath SHALL be EXPO_WIDTH+2 bits signed internally so that overflow and underflow are detectable.

Verification
REQ-032 Accept 0x3FC00000 + 0x40100000 with op_in=0 -> result_out 0x40700000, out_valid_out exactly 4 edges after accept.
REQ-033 Accept 0x3F800000 - 0x3F400000 with op_in=1 -> 0x3E800000 (left-normalise by 2). Accept 0x3F800000 - 0x3F800000 -> 0x00000000, zero_out=1.
REQ-034 Accept 0x3F800000 + 0x33800000 -> 0x3F800000 (truncation). Accept 0x7F7FFFFF + 0x7F7FFFFF -> 0x7F800000, overflow_out=1.
REQ-035 Hold out_ready_in=0 for 3 cycles in DONE -> result_out stable and in_ready_out=0 throughout; a second in_valid_in pulse is ignored; the next accept is possible only after DONE->IDLE.
REQ-036 Assert rst_in while in ADD -> out_valid_out=0 and result_out=0 immediately; in_ready_out=1 one edge after release; no stale result is presented.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared FSM encoding and width constants for the
// sequential floating-point add/subtract unit.
package fp_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALIGN,
    S_ADD,
    S_NORM,
    S_DONE
  } state_t;

  localparam int EXPO_W_DEF = 8;
  localparam int MENT_W_DEF = 23;

  // Sliced down to EXPO_WIDTH by the user
  localparam logic [31:0] EXPO_ALL_ONES = '1;

endpackage

// File: rtl/leading_one_detector.sv
// Finds the highest set bit of a vector; valid is low
// when the vector is all zero.
module leading_one_detector #(
  parameter int WIDTH = 25,
  localparam int PW = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  output logic [PW-1:0]    pos,
  output logic             valid
);

  always_comb begin
    pos   = '0;
    valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i]) begin
        pos   = PW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_addsub_sequencer.sv
// Multi-cycle FP add/subtract: align, add, normalise,
// then hold the result until the consumer takes it.
module fp_addsub_sequencer
  import fp_pkg::*;
#(
  parameter int EXPO_WIDTH = EXPO_W_DEF,
  parameter int MENT_WIDTH = MENT_W_DEF,
  parameter int DATA_WIDTH = 1 + EXPO_WIDTH + MENT_WIDTH
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  in_valid_in,
  output logic                  in_ready_out,
  input  logic [DATA_WIDTH-1:0] floating1_in,
  input  logic [DATA_WIDTH-1:0] floating2_in,
  input  logic                  op_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [DATA_WIDTH-1:0] result_out,
  output logic                  zero_out,
  output logic                  overflow_out,
  output logic                  underflow_out
);

  localparam int SW = MENT_WIDTH + 2;
  localparam int XW = EXPO_WIDTH + 2;
  localparam int PW = $clog2(SW);
  localparam logic [EXPO_WIDTH-1:0] EXP_MAX =
    EXPO_ALL_ONES[EXPO_WIDTH-1:0];
  localparam logic signed [XW-1:0] X_ZERO = '0;
  localparam logic signed [XW-1:0] X_MAX =
    $signed({2'b00, EXP_MAX});

  state_t state, state_nx;
  logic   armed;

  logic [DATA_WIDTH-1:0] f1, f2;
  logic                  op;

  logic [EXPO_WIDTH-1:0] big_exp;
  logic [SW-1:0]         big_sig, small_sig, sum;
  logic                  sub, sign, special;

  logic [DATA_WIDTH-1:0] result;
  logic                  zero, ovf, unf;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:
        if (in_valid_in && in_ready_out)
          state_nx = S_ALIGN;
      S_ALIGN: state_nx = S_ADD;
      S_ADD:   state_nx = S_NORM;
      S_NORM:  state_nx = S_DONE;
      S_DONE:
        if (out_ready_in) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready_out  = armed && (state == S_IDLE);
    out_valid_out = (state == S_DONE);
  end

  // Keeps ready low while reset is held and for no longer
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) armed <= 1'b0;
    else        armed <= 1'b1;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      f1 <= '0;
      f2 <= '0;
      op <= 1'b0;
    end else if (in_valid_in && in_ready_out) begin
      f1 <= floating1_in;
      f2 <= floating2_in;
      op <= op_in;
    end
  end

  logic                  s1, s2;
  logic [EXPO_WIDTH-1:0] e1, e2, diff;
  logic [SW-1:0]         g1, g2, shifted;
  logic                  swap, inf1, inf2;

  always_comb begin
    s1   = f1[DATA_WIDTH-1];
    s2   = f2[DATA_WIDTH-1] ^ op;
    e1   = f1[DATA_WIDTH-2 -: EXPO_WIDTH];
    e2   = f2[DATA_WIDTH-2 -: EXPO_WIDTH];
    g1   = (e1 == '0) ? '0 : {2'b01, f1[MENT_WIDTH-1:0]};
    g2   = (e2 == '0) ? '0 : {2'b01, f2[MENT_WIDTH-1:0]};
    inf1 = (e1 == EXP_MAX);
    inf2 = (e2 == EXP_MAX);
    swap = (e2 > e1) || ((e2 == e1) && (g2 > g1));
    diff = swap ? (e2 - e1) : (e1 - e2);
    shifted = swap ? g1 : g2;
    if (32'(diff) >= SW) shifted = '0;
    else                 shifted = shifted >> diff;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      big_exp   <= '0;
      big_sig   <= '0;
      small_sig <= '0;
      sub       <= 1'b0;
      sign      <= 1'b0;
      special   <= 1'b0;
    end else if (state == S_ALIGN) begin
      big_exp   <= swap ? e2 : e1;
      big_sig   <= swap ? g2 : g1;
      small_sig <= shifted;
      sub       <= s1 ^ s2;
      special   <= inf1 | inf2;
      if (inf1 | inf2) sign <= inf1 ? s1 : s2;
      else             sign <= swap ? s2 : s1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)
      sum <= '0;
    else if (state == S_ADD)
      sum <= sub ? (big_sig - small_sig)
                 : (big_sig + small_sig);
  end

  logic [PW-1:0]          lead_pos;
  logic                   lead_ok;
  logic [XW-1:0]          shamt;
  logic signed [XW-1:0]   exp_n;
  logic [MENT_WIDTH-1:0]  mant;
  logic [DATA_WIDTH-1:0]  res_nx;
  logic                   zero_nx, ovf_nx, unf_nx;

  leading_one_detector #(.WIDTH(SW)) u_lod (
    .data  (sum),
    .pos   (lead_pos),
    .valid (lead_ok)
  );

  always_comb begin
    shamt = XW'(MENT_WIDTH) - XW'(lead_pos);
    if (sum[SW-1]) begin
      exp_n = $signed({2'b00, big_exp} + XW'(1));
      mant  = sum[MENT_WIDTH:1];
    end else begin
      exp_n = $signed({2'b00, big_exp} - shamt);
      mant  = MENT_WIDTH'(sum << shamt);
    end
    res_nx  = '0;
    zero_nx = 1'b0;
    ovf_nx  = 1'b0;
    unf_nx  = 1'b0;
    if (special) begin
      res_nx = {sign, EXP_MAX, {MENT_WIDTH{1'b0}}};
    end else if (!lead_ok) begin
      zero_nx = 1'b1;
    end else if (exp_n >= X_MAX) begin
      res_nx = {sign, EXP_MAX, {MENT_WIDTH{1'b0}}};
      ovf_nx = 1'b1;
    end else if (exp_n <= X_ZERO) begin
      zero_nx = 1'b1;
      unf_nx  = 1'b1;
    end else begin
      res_nx = {sign, exp_n[EXPO_WIDTH-1:0], mant};
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      result <= '0;
      zero   <= 1'b0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
    end else if (state == S_NORM) begin
      result <= res_nx;
      zero   <= zero_nx;
      ovf    <= ovf_nx;
      unf    <= unf_nx;
    end
  end

  assign result_out    = result;
  assign zero_out      = zero;
  assign overflow_out  = ovf;
  assign underflow_out = unf;

endmodule

// File: tb/tb_fp_addsub_sequencer.sv
// Directed vectors, handshake corner cases and random
// operands checked against an arithmetic reference model.
module tb_fp_addsub_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [31:0] f1, f2;
  logic        op;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        zero, ovf, unf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fp_addsub_sequencer dut (
    .clk_in        (clk),
    .rst_in        (rst),
    .in_valid_in   (in_valid),
    .in_ready_out  (in_ready),
    .floating1_in  (f1),
    .floating2_in  (f2),
    .op_in         (op),
    .out_valid_out (out_valid),
    .out_ready_in  (out_ready),
    .result_out    (result),
    .zero_out      (zero),
    .overflow_out  (ovf),
    .underflow_out (unf)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        o;
    logic [31:0] res;
    logic [2:0]  flags;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic [2:0]  flags;
  } res_t;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Plain arithmetic on integer significands; flags are {zero,ovf,unf}
  function automatic res_t model(input logic [31:0] a,
                                 input logic [31:0] b,
                                 input logic o);
    res_t   r;
    int     ea, eb, el, es, d, e;
    longint ga, gb, gl, gs, v;
    bit     sa, sb, sl, sw;
    r.res = '0;
    r.flags = 3'b000;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    sa = a[31];
    sb = b[31] ^ o;
    if (ea == 255 || eb == 255) begin
      r.res = {(ea == 255) ? sa : sb, 8'hFF, 23'h0};
      return r;
    end
    ga = (ea == 0) ? 0 : longint'(a[22:0]) + 64'h80_0000;
    gb = (eb == 0) ? 0 : longint'(b[22:0]) + 64'h80_0000;
    sw = (eb > ea) || (eb == ea && gb > ga);
    el = sw ? eb : ea;
    es = sw ? ea : eb;
    gl = sw ? gb : ga;
    gs = sw ? ga : gb;
    sl = sw ? sb : sa;
    d = el - es;
    gs = (d >= 25) ? 0 : (gs >> d);
    v = (sa != sb) ? gl - gs : gl + gs;
    if (v == 0) begin
      r.flags = 3'b100;
      return r;
    end
    e = el;
    while (v >= 64'h100_0000) begin v = v >> 1; e++; end
    while (v < 64'h80_0000) begin v = v << 1; e--; end
    if (e >= 255) begin
      r.res = {sl, 8'hFF, 23'h0};
      r.flags = 3'b010;
    end else if (e <= 0) begin
      r.flags = 3'b101;
    end else begin
      r.res = {sl, 8'(e), 23'(v)};
    end
    return r;
  endfunction

  task automatic do_op(input logic [31:0] a,
                       input logic [31:0] b,
                       input logic o,
                       output logic [31:0] r,
                       output logic [2:0] fl);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("ready_wait", 32'(in_ready), 32'd1);
    f1 = a; f2 = b; op = o; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 10) begin
      @(posedge clk); #1; n++;
    end
    check("latency", 32'(n), 32'd4);
    r  = result;
    fl = {zero, ovf, unf};
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[9];
    logic [31:0] r, a, b;
    logic [2:0]  fl;
    res_t        m;
    int          stale;

    tbl[0] = '{32'h3FC00000, 32'h40100000, 1'b0, 32'h40700000, 3'b000};
    tbl[1] = '{32'h3F800000, 32'h3F400000, 1'b1, 32'h3E800000, 3'b000};
    tbl[2] = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 3'b100};
    tbl[3] = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 3'b000};
    tbl[4] = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 3'b010};
    tbl[5] = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3'b000};
    tbl[6] = '{32'h00400000, 32'h3F800000, 1'b0, 32'h3F800000, 3'b000};
    tbl[7] = '{32'h00800000, 32'h00C00000, 1'b1, 32'h00000000, 3'b101};
    tbl[8] = '{32'hBF800000, 32'h3F400000, 1'b0, 32'hBE800000, 3'b000};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    f1 = '0; f2 = '0; op = 1'b0;
    #3;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_flags", 32'({zero, ovf, unf}), 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("ready_pre_edge", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("ready_post_edge", 32'(in_ready), 32'd1);

    for (int i = 0; i < 9; i++) begin
      do_op(tbl[i].a, tbl[i].b, tbl[i].o, r, fl);
      check($sformatf("vec%0d_res", i), r, tbl[i].res);
      check($sformatf("vec%0d_flags", i), 32'(fl),
            32'(tbl[i].flags));
    end

    // Stall in DONE with a stray request pending
    f1 = 32'h3FC00000; f2 = 32'h40100000; op = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    f1 = 32'h7F7FFFFF; f2 = 32'h7F7FFFFF; op = 1'b1;
    for (int n = 0; n < 10 && !out_valid; n++) begin
      @(posedge clk); #1;
    end
    for (int c = 0; c < 3; c++) begin
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_result", result, 32'h40700000);
      check("hold_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("hold_result_end", result, 32'h40700000);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    check("stray_not_taken", 32'(in_ready), 32'd1);
    do_op(32'h3F800000, 32'h3F400000, 1'b1, r, fl);
    check("after_hold_res", r, 32'h3E800000);

    // Reset while the operation sits in ADD
    f1 = 32'h40000000; f2 = 32'h40000000; op = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_result", result, 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_ready_low", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_ready_high", 32'(in_ready), 32'd1);
    stale = 0;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) stale++;
      @(posedge clk); #1;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 2 == 1)
        b[30:23] = a[30:23] - 8'($urandom_range(0, 3));
      m = model(a, b, 1'($urandom_range(0, 1)));
      op = 1'b0;
      m = model(a, b, 1'(i % 3 == 0));
      do_op(a, b, 1'(i % 3 == 0), r, fl);
      check($sformatf("rand%0d_res", i), r, m.res);
      check($sformatf("rand%0d_flags", i), 32'(fl),
            32'(m.flags));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
